// File: rtl/layer0_sequencer.sv
// layer0_sequencer: frame controller for the layer-0 conv datapath.
// On a ready request it raster-scans the image. For every output pixel it fetches the
// nine 3x3 window pixels (row-major, centre at k=4) and then issues one result write per
// kernel. done pulses for one cycle after the last write of the frame.
//
// Ports:
//   clk_i            system clock, rising edge
//   rst_ni           asynchronous active-low reset
//   ready_i          start request, sampled in idle only
//   busy_o           high from the first fetch cycle through done
//   iaddr_o          image read address (zero for padded window positions)
//   en4mem_o         window register load enables, one-hot while fetching
//   mux4mem_o        per-register source: 1 = image data, 0 = zero padding
//   num_of_kernel_o  conv kernel select for the current write
//   cwr_o            result write strobe
//   caddr_wr_o       result write address = current output pixel index
//   csel_o           result memory select (001 kernel0, 010 kernel1)
//   done_o           one-cycle end-of-frame pulse
// All outputs decode registered state only; there is no input-to-output path.
module layer0_sequencer #(
  parameter int unsigned IMG_W = 64,
  parameter int unsigned IMG_H = 64,
  parameter int unsigned AW    = 12
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          ready_i,
  output logic          busy_o,
  output logic [AW-1:0] iaddr_o,
  output logic [8:0]    en4mem_o,
  output logic [8:0]    mux4mem_o,
  output logic          num_of_kernel_o,
  output logic          cwr_o,
  output logic [AW-1:0] caddr_wr_o,
  output logic [2:0]    csel_o,
  output logic          done_o
);

  localparam int unsigned ColW = $clog2(IMG_W);
  localparam int unsigned RowW = $clog2(IMG_H);

  typedef enum logic [2:0] {StIdle, StFetch, StWr0, StWr1, StDone} state_e;

  state_e          state_q, state_d;
  logic [RowW-1:0] row_q, row_d;
  logic [ColW-1:0] col_q, col_d;
  logic [3:0]      k_q, k_d;

  logic            last_col, last_row;
  logic [1:0]      wy, wx;
  logic [RowW+1:0] r_ext;
  logic [ColW+1:0] c_ext;
  logic            in_bounds;

  assign last_col = (col_q == ColW'(IMG_W - 1));
  assign last_row = (row_q == RowW'(IMG_H - 1));

  // Window offset as k/3 and k%3 (0..2); the -1 bias is applied in the sums below.
  always_comb begin
    wy = 2'd0;
    wx = 2'd0;
    case (k_q)
      4'd0: begin wy = 2'd0; wx = 2'd0; end
      4'd1: begin wy = 2'd0; wx = 2'd1; end
      4'd2: begin wy = 2'd0; wx = 2'd2; end
      4'd3: begin wy = 2'd1; wx = 2'd0; end
      4'd4: begin wy = 2'd1; wx = 2'd1; end
      4'd5: begin wy = 2'd1; wx = 2'd2; end
      4'd6: begin wy = 2'd2; wx = 2'd0; end
      4'd7: begin wy = 2'd2; wx = 2'd1; end
      4'd8: begin wy = 2'd2; wx = 2'd2; end
      default: begin wy = 2'd0; wx = 2'd0; end
    endcase
  end

  // Two extra bits: the MSB flags -1 (two's complement), the next one flags == size.
  // Either set means the window position falls outside the image.
  assign r_ext = {2'b00, row_q} + (RowW+2)'(wy) - (RowW+2)'(1);
  assign c_ext = {2'b00, col_q} + (ColW+2)'(wx) - (ColW+2)'(1);
  assign in_bounds = (r_ext[RowW+1:RowW] == 2'b00) && (c_ext[ColW+1:ColW] == 2'b00);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      row_q   <= '0;
      col_q   <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      k_q     <= k_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    k_d     = k_q;
    case (state_q)
      StIdle: begin
        row_d = '0;
        col_d = '0;
        k_d   = '0;
        if (ready_i) state_d = StFetch;
      end
      StFetch: begin
        if (k_q == 4'd8) begin
          k_d     = '0;
          state_d = StWr0;
        end else begin
          k_d = k_q + 4'd1;
        end
      end
      StWr0: state_d = StWr1;
      StWr1: begin
        if (last_col) begin
          col_d = '0;
          row_d = row_q + RowW'(1);
        end else begin
          col_d = col_q + ColW'(1);
        end
        state_d = (last_col && last_row) ? StDone : StFetch;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy_o          = (state_q != StIdle);
    done_o          = (state_q == StDone);
    iaddr_o         = '0;
    en4mem_o        = '0;
    mux4mem_o       = '0;
    num_of_kernel_o = 1'b0;
    cwr_o           = 1'b0;
    caddr_wr_o      = '0;
    csel_o          = 3'b000;
    case (state_q)
      StFetch: begin
        // Padded positions still load their register, capturing zero via the mux.
        en4mem_o = 9'b1 << k_q;
        if (in_bounds) begin
          mux4mem_o = 9'b1 << k_q;
          iaddr_o   = AW'({r_ext[RowW-1:0], c_ext[ColW-1:0]});
        end
      end
      StWr0: begin
        cwr_o      = 1'b1;
        csel_o     = 3'b001;
        caddr_wr_o = AW'({row_q, col_q});
      end
      StWr1: begin
        num_of_kernel_o = 1'b1;
        cwr_o           = 1'b1;
        csel_o          = 3'b010;
        caddr_wr_o      = AW'({row_q, col_q});
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_layer0_sequencer.sv
// Bench for layer0_sequencer: a table of per-cycle vectors for the first pixels of a
// frame, then hand sequences for edge pixels, async reset, mid-frame ready and a full
// frame with done timing.
module tb_layer0_sequencer;

  logic        clk;
  logic        rst_n;
  logic        ready;
  logic        busy;
  logic [11:0] iaddr;
  logic [8:0]  en4mem;
  logic [8:0]  mux4mem;
  logic        nok;
  logic        cwr;
  logic [11:0] caddr;
  logic [2:0]  csel;
  logic        done;

  int n_vec = 0;
  int n_bad = 0;

  layer0_sequencer #(.IMG_W(64), .IMG_H(64), .AW(12)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .ready_i         (ready),
    .busy_o          (busy),
    .iaddr_o         (iaddr),
    .en4mem_o        (en4mem),
    .mux4mem_o       (mux4mem),
    .num_of_kernel_o (nok),
    .cwr_o           (cwr),
    .caddr_wr_o      (caddr),
    .csel_o          (csel),
    .done_o          (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic        busy;
    logic [11:0] ia;
    logic [8:0]  en;
    logic [8:0]  mx;
    logic        nok;
    logic        cwr;
    logic [11:0] ca;
    logic [2:0]  cs;
    logic        dn;
  } vec_t;

  vec_t tbl[18];

  function automatic vec_t mk(input logic rdy, input logic bsy, input logic [11:0] ia,
                              input logic [8:0] en, input logic [8:0] mx, input logic nk,
                              input logic wr, input logic [11:0] ca, input logic [2:0] cs,
                              input logic dn);
    vec_t v;
    v.rdy = rdy; v.busy = bsy; v.ia = ia; v.en = en; v.mx = mx;
    v.nok = nk; v.cwr = wr; v.ca = ca; v.cs = cs; v.dn = dn;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({busy, iaddr, en4mem, mux4mem, nok, cwr, caddr, csel, done});
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    @(negedge clk);
    ready = 1'b1;
    @(posedge clk);
    #1;
    ready = 1'b0;
  endtask

  // Independent window model: checks the 9 fetches and 2 writes of one pixel.
  task automatic check_pixel(input int row, input int col, input int exp_ca);
    for (int k = 0; k < 9; k++) begin
      int  r, c;
      bit  inb;
      r   = row + k / 3 - 1;
      c   = col + k % 3 - 1;
      inb = (r >= 0) && (r < 64) && (c >= 0) && (c < 64);
      chk($sformatf("px(%0d,%0d) k%0d iaddr", row, col, k), 64'(iaddr),
          inb ? 64'(r * 64 + c) : 64'd0);
      chk($sformatf("px(%0d,%0d) k%0d en4mem", row, col, k), 64'(en4mem), 64'(1) << k);
      chk($sformatf("px(%0d,%0d) k%0d mux4mem", row, col, k), 64'(mux4mem),
          inb ? (64'(1) << k) : 64'd0);
      tick(1);
    end
    chk($sformatf("px(%0d,%0d) wr0", row, col), 64'({en4mem, cwr, csel, nok, caddr}),
        64'({9'h000, 1'b1, 3'b001, 1'b0, 12'(exp_ca)}));
    tick(1);
    chk($sformatf("px(%0d,%0d) wr1", row, col), 64'({en4mem, cwr, csel, nok, caddr}),
        64'({9'h000, 1'b1, 3'b010, 1'b1, 12'(exp_ca)}));
    tick(1);
  endtask

  initial begin
    int   cnt, dn_cnt, dn_s;
    logic [11:0] last_ca;
    bit   busy_seen;

    //                rdy   busy  iaddr   en4mem  mux4mem nok   cwr   caddr  csel    done
    tbl[0]  = mk(1'b0, 1'b0, 12'd0,  9'h000, 9'h000, 1'b0, 1'b0, 12'd0, 3'b000, 1'b0);
    tbl[1]  = mk(1'b1, 1'b1, 12'd0,  9'h001, 9'h000, 1'b0, 1'b0, 12'd0, 3'b000, 1'b0);
    tbl[2]  = mk(1'b0, 1'b1, 12'd0,  9'h002, 9'h000, 1'b0, 1'b0, 12'd0, 3'b000, 1'b0);
    tbl[3]  = mk(1'b0, 1'b1, 12'd0,  9'h004, 9'h000, 1'b0, 1'b0, 12'd0, 3'b000, 1'b0);
    tbl[4]  = mk(1'b0, 1'b1, 12'd0,  9'h008, 9'h000, 1'b0, 1'b0, 12'd0, 3'b000, 1'b0);
    tbl[5]  = mk(1'b1, 1'b1, 12'd0,  9'h010, 9'h010, 1'b0, 1'b0, 12'd0, 3'b000, 1'b0);
    tbl[6]  = mk(1'b0, 1'b1, 12'd1,  9'h020, 9'h020, 1'b0, 1'b0, 12'd0, 3'b000, 1'b0);
    tbl[7]  = mk(1'b0, 1'b1, 12'd0,  9'h040, 9'h000, 1'b0, 1'b0, 12'd0, 3'b000, 1'b0);
    tbl[8]  = mk(1'b0, 1'b1, 12'd64, 9'h080, 9'h080, 1'b0, 1'b0, 12'd0, 3'b000, 1'b0);
    tbl[9]  = mk(1'b0, 1'b1, 12'd65, 9'h100, 9'h100, 1'b0, 1'b0, 12'd0, 3'b000, 1'b0);
    tbl[10] = mk(1'b0, 1'b1, 12'd0,  9'h000, 9'h000, 1'b0, 1'b1, 12'd0, 3'b001, 1'b0);
    tbl[11] = mk(1'b0, 1'b1, 12'd0,  9'h000, 9'h000, 1'b1, 1'b1, 12'd0, 3'b010, 1'b0);
    tbl[12] = mk(1'b1, 1'b1, 12'd0,  9'h001, 9'h000, 1'b0, 1'b0, 12'd0, 3'b000, 1'b0);
    tbl[13] = mk(1'b0, 1'b1, 12'd0,  9'h002, 9'h000, 1'b0, 1'b0, 12'd0, 3'b000, 1'b0);
    tbl[14] = mk(1'b0, 1'b1, 12'd0,  9'h004, 9'h000, 1'b0, 1'b0, 12'd0, 3'b000, 1'b0);
    tbl[15] = mk(1'b0, 1'b1, 12'd0,  9'h008, 9'h008, 1'b0, 1'b0, 12'd0, 3'b000, 1'b0);
    tbl[16] = mk(1'b0, 1'b1, 12'd1,  9'h010, 9'h010, 1'b0, 1'b0, 12'd0, 3'b000, 1'b0);
    tbl[17] = mk(1'b0, 1'b1, 12'd2,  9'h020, 9'h020, 1'b0, 1'b0, 12'd0, 3'b000, 1'b0);

    // Async reset asserted mid-cycle, then 100 idle cycles with ready low.
    rst_n = 1'b1;
    ready = 1'b0;
    #3 rst_n = 1'b0;
    #1 chk("reset outputs", all_outs(), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    busy_seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (busy !== 1'b0) busy_seen = 1'b1;
    end
    chk("idle 100 cycles busy", 64'(busy_seen), 64'd0);

    // Table: idle, start, pixel (0,0) fetch+writes, first fetches of pixel (0,1).
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      ready = tbl[i].rdy;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d busy", i), 64'(busy), 64'(tbl[i].busy));
      chk($sformatf("vec%0d iaddr", i), 64'(iaddr), 64'(tbl[i].ia));
      chk($sformatf("vec%0d en4mem", i), 64'(en4mem), 64'(tbl[i].en));
      chk($sformatf("vec%0d mux4mem", i), 64'(mux4mem), 64'(tbl[i].mx));
      chk($sformatf("vec%0d wr", i), 64'({nok, cwr, caddr, csel}),
          64'({tbl[i].nok, tbl[i].cwr, tbl[i].ca, tbl[i].cs}));
      chk($sformatf("vec%0d done", i), 64'(done), 64'(tbl[i].dn));
    end
    ready = 1'b0;

    // Mid-frame async reset: outputs clear without a clock edge.
    #3 rst_n = 1'b0;
    #1 chk("midframe reset outputs", all_outs(), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Frame A: edge pixels, interior pixel, ready ignored, reset at pixel 1000.
    start_frame();
    tick(63 * 11);
    check_pixel(0, 63, 63);
    check_pixel(1, 0, 64);
    tick((330 - 65) * 11);
    check_pixel(5, 10, 330);
    ready = 1'b1;
    tick((1000 - 331) * 11);
    ready = 1'b0;
    // Pixel 1000 = (15,40); k=0 reads (14,39).
    chk("px1000 k0 iaddr", 64'(iaddr), 64'd935);
    chk("px1000 k0 busy/en", 64'({busy, en4mem}), 64'({1'b1, 9'h001}));
    #3 rst_n = 1'b0;
    #1 chk("px1000 reset outputs", all_outs(), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Frame B: full frame from pixel 0, then back-to-back restart with ready held.
    start_frame();
    cnt = 0;
    dn_cnt = 0;
    dn_s = -1;
    last_ca = '0;
    for (int s = 0; s <= 45058; s++) begin
      if (s > 0) tick(1);
      if (cwr === 1'b1) begin
        cnt++;
        last_ca = caddr;
      end
      if (done === 1'b1) begin
        dn_cnt++;
        dn_s = s;
      end
      if (s == 0) chk("restart px0 k0", 64'({busy, iaddr, en4mem, mux4mem}),
                      64'({1'b1, 12'd0, 9'h001, 9'h000}));
      if (s == 9) chk("restart px0 wr0", 64'({cwr, csel, caddr}),
                      64'({1'b1, 3'b001, 12'd0}));
      if (s == 45056) chk("done cycle busy", 64'(busy), 64'd1);
      if (s == 45057) chk("after done busy", 64'({busy, done}), 64'd0);
      if (s == 45058) chk("ready-held restart", 64'({busy, en4mem}), 64'({1'b1, 9'h001}));
      ready = (s >= 100 && s < 200) || (s >= 45050 && s <= 45057);
    end
    ready = 1'b0;
    chk("frame cwr pulses", 64'(cnt), 64'd8192);
    chk("frame last caddr", 64'(last_ca), 64'd4095);
    chk("done pulse count", 64'(dn_cnt), 64'd1);
    chk("done cycle", 64'(dn_s), 64'd45056);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
